// File: rtl/powlib_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready handshakes on both ports.
// Wrap-counter pointers over a dual-port RAM; one slot is kept free to tell full from empty.
module powlib_sync_fifo #(
    parameter int W = 16,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] wrdata,
    input  logic         wrvld,
    output logic         wrrdy,
    output logic [W-1:0] rddata,
    output logic         rdvld,
    input  logic         rdrdy
);

    localparam int AW = (D > 1) ? $clog2(D) : 1;
    localparam logic [AW-1:0] LAST = AW'(D - 1);

    if (D < 2) begin : g_bad_depth
        $error("powlib_sync_fifo: D must be at least 2 (got %0d)", D);
    end

    logic [W-1:0]  mem [D];
    logic [AW-1:0] wrptr_q, wrptr_d;
    logic [AW-1:0] rdptr_q, rdptr_d;
    logic [AW-1:0] rdptrm1_q, rdptrm1_d;
    logic          wrinc, rdinc;

    function automatic logic [AW-1:0] wrapInc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + AW'(1);
    endfunction

    // Flags depend only on registered pointers, never on wrvld/rdrdy.
    assign wrrdy  = (wrptr_q != rdptrm1_q);
    assign rdvld  = (rdptr_q != wrptr_q);
    assign wrinc  = wrvld & wrrdy;
    assign rdinc  = rdvld & rdrdy;
    assign rddata = mem[rdptr_q];

    always_comb begin
        wrptr_d   = wrinc ? wrapInc(wrptr_q) : wrptr_q;
        rdptr_d   = rdinc ? wrapInc(rdptr_q) : rdptr_q;
        rdptrm1_d = rdinc ? rdptr_q : rdptrm1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrptr_q   <= '0;
            rdptr_q   <= '0;
            rdptrm1_q <= LAST;
        end else begin
            wrptr_q   <= wrptr_d;
            rdptr_q   <= rdptr_d;
            rdptrm1_q <= rdptrm1_d;
        end
    end

    // RAM is deliberately not reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wrinc) begin
            mem[wrptr_q] <= wrdata;
        end
    end

endmodule

// File: tb/tb_powlib_sync_fifo.sv
// Randomized/directed bench for powlib_sync_fifo (D=8 and D=5 instances)
// checked against a queue-based model of FIFO occupancy and order.
module tb_powlib_sync_fifo;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst    [2];
    logic [W-1:0] wrdata [2];
    logic         wrvld  [2];
    logic         wrrdy  [2];
    logic [W-1:0] rddata [2];
    logic         rdvld  [2];
    logic         rdrdy  [2];

    logic [W-1:0] q0 [$];
    logic [W-1:0] q1 [$];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    powlib_sync_fifo #(.W(W), .D(8)) dut8 (
        .clk(clk), .rst(rst[0]), .wrdata(wrdata[0]), .wrvld(wrvld[0]), .wrrdy(wrrdy[0]),
        .rddata(rddata[0]), .rdvld(rdvld[0]), .rdrdy(rdrdy[0])
    );

    powlib_sync_fifo #(.W(W), .D(5)) dut5 (
        .clk(clk), .rst(rst[1]), .wrdata(wrdata[1]), .wrvld(wrvld[1]), .wrrdy(wrrdy[1]),
        .rddata(rddata[1]), .rdvld(rdvld[1]), .rdrdy(rdrdy[1])
    );

    function automatic int capOf(input int k);
        return (k == 0) ? 7 : 4;
    endfunction

    function automatic int sizeOf(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic checkOutput(input int k);
        int n;
        logic expVld, expRdy;
        logic [W-1:0] expData;
        n = sizeOf(k);
        expVld = (n != 0);
        expRdy = (n < capOf(k));
        vectors++;
        assert (rdvld[k] === expVld) else begin
            miscompares++;
            $error("[TB] FAIL rdvld dut%0d observed %b expected %b", k, rdvld[k], expVld);
        end
        vectors++;
        assert (wrrdy[k] === expRdy) else begin
            miscompares++;
            $error("[TB] FAIL wrrdy dut%0d observed %b expected %b", k, wrrdy[k], expRdy);
        end
        if (expVld) begin
            expData = (k == 0) ? q0[0] : q1[0];
            vectors++;
            assert (rddata[k] === expData) else begin
                miscompares++;
                $error("[TB] FAIL rddata dut%0d observed %h expected %h", k, rddata[k], expData);
            end
        end
    endtask

    // Update the model with what the edge just accepted, judged from pre-edge occupancy.
    task automatic modelEdge(input int k);
        int  n;
        bit  rdAcc, wrAcc;
        n = sizeOf(k);
        if (!rst[k]) begin
            if (k == 0) q0.delete(); else q1.delete();
        end else begin
            rdAcc = rdrdy[k] && (n > 0);
            wrAcc = wrvld[k] && (n < capOf(k));
            if (k == 0) begin
                if (rdAcc) void'(q0.pop_front());
                if (wrAcc) q0.push_back(wrdata[k]);
            end else begin
                if (rdAcc) void'(q1.pop_front());
                if (wrAcc) q1.push_back(wrdata[k]);
            end
        end
    endtask

    task automatic applyStimulus(input int k, input bit wv, input logic [W-1:0] wd, input bit rr);
        for (int j = 0; j < 2; j++) begin
            wrvld[j]  = 1'b0;
            rdrdy[j]  = 1'b0;
            wrdata[j] = '0;
        end
        wrvld[k]  = wv;
        wrdata[k] = wd;
        rdrdy[k]  = rr;
    endtask

    // Called at a falling edge: check both DUTs, take one rising edge, update models.
    task automatic tick();
        checkOutput(0);
        checkOutput(1);
        @(posedge clk);
        modelEdge(0);
        modelEdge(1);
        @(negedge clk);
    endtask

    initial begin
        for (int j = 0; j < 2; j++) begin
            rst[j] = 1'b0;
        end
        applyStimulus(0, 1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        q0.delete();
        q1.delete();

        // Reset state, then fill D=8 past capacity with 0x0008 refused.
        tick();
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(0, 1'b1, W'(i), 1'b0);
            tick();
        end
        applyStimulus(0, 1'b1, 16'h0008, 1'b0);
        repeat (3) tick();

        // Drain in order.
        applyStimulus(0, 1'b0, '0, 1'b1);
        repeat (9) tick();

        // Streaming with simultaneous read/write across pointer wrap.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1'b1, 16'h0100 + W'(i), 1'b1);
            tick();
        end
        applyStimulus(0, 1'b0, '0, 1'b1);
        repeat (3) tick();

        // Mid-operation reset discards buffered words.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1'b1, 16'h0A00 + W'(i), 1'b0);
            tick();
        end
        applyStimulus(0, 1'b0, '0, 1'b0);
        rst[0] = 1'b0;
        tick();
        rst[0] = 1'b1;
        applyStimulus(0, 1'b1, 16'hBEEF, 1'b0);
        tick();
        applyStimulus(0, 1'b0, '0, 1'b1);
        repeat (3) tick();

        // D=5: fill, then drain/refill three times so pointers wrap 4->0.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 1'b1, 16'h0500 + W'(i), 1'b0);
            tick();
        end
        for (int r = 0; r < 3; r++) begin
            applyStimulus(1, 1'b0, '0, 1'b1);
            repeat (5) tick();
            for (int i = 0; i < 6; i++) begin
                applyStimulus(1, 1'b1, 16'h0600 + W'(r * 16 + i), 1'b0);
                tick();
            end
        end
        applyStimulus(1, 1'b0, '0, 1'b1);
        repeat (5) tick();

        // Random traffic on both instances, with occasional resets.
        for (int c = 0; c < 400; c++) begin
            for (int j = 0; j < 2; j++) begin
                wrvld[j]  = 1'($urandom_range(0, 1));
                rdrdy[j]  = 1'($urandom_range(0, 1));
                wrdata[j] = W'($urandom);
                rst[j]    = ($urandom_range(0, 59) != 0);
            end
            tick();
        end
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        applyStimulus(0, 1'b0, '0, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
